// File: rtl/d_mem_responder.sv
// Memory-side responder for the data cache write-through port: fixed-latency
// strobe/ready handshake onto a word RAM plus a small MMIO window at 0x1faf_xxxx.
module d_mem_responder #(
  parameter int unsigned MEM_AW    = 12,
  parameter int unsigned LATENCY   = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        m_strobe,
  input  logic        m_rw,
  input  logic [31:0] m_a,
  input  logic [31:0] m_din,
  input  logic [3:0]  m_wen,
  input  logic [15:0] sw,
  output logic [31:0] m_dout,
  output logic        m_ready,
  output logic [15:0] led
);

  localparam int unsigned DEPTH = 1 << MEM_AW;
  localparam int unsigned CW    = 4;
  localparam int unsigned WAW   = 30;
  localparam logic [15:0] MMIO_BASE = 16'h1faf;
  localparam logic [13:0] OFF_LED   = 14'd0;
  localparam logic [13:0] OFF_SW    = 14'd1;
  localparam logic [13:0] OFF_CNT   = 14'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WAW-1:0]   req_a_q, req_a_d;
  logic             req_rw_q, req_rw_d;
  logic [31:0]      req_din_q, req_din_d;
  logic [3:0]       req_wen_q, req_wen_d;
  logic [31:0]      m_dout_q, m_dout_d;
  logic             m_ready_q, m_ready_d;
  logic [15:0]      led_q, led_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [15:0]      sw_s1_q, sw_s1_d;
  logic [15:0]      sw_s2_q, sw_s2_d;

  logic [31:0]      mem [DEPTH];

  logic [WAW-1:0]   cur_w_c;
  logic             cur_rw_c;
  logic             cur_mmio_c;
  logic [31:0]      rd_data_c;
  logic             wr_c;
  logic             wr_mmio_c;
  logic             unused_c;

  // Byte offset within a word carries no meaning on this port.
  assign unused_c = ^m_a[1:0];

  // In IDLE the request is still on the bus, so a zero-latency read must decode it live.
  always_comb begin
    cur_w_c    = (state_q == S_IDLE) ? m_a[31:2] : req_a_q;
    cur_rw_c   = (state_q == S_IDLE) ? m_rw : req_rw_q;
    cur_mmio_c = (cur_w_c[29:14] == MMIO_BASE);
    rd_data_c  = '0;
    if (cur_mmio_c) begin
      case (cur_w_c[13:0])
        OFF_LED: rd_data_c = {16'h0, led_q};
        OFF_SW:  rd_data_c = {16'h0, sw_s2_q};
        OFF_CNT: rd_data_c = cyc_q;
        default: rd_data_c = '0;
      endcase
    end else begin
      rd_data_c = mem[cur_w_c[MEM_AW-1:0]];
    end
  end

  assign wr_c      = (state_q == S_ACK) && req_rw_q;
  assign wr_mmio_c = (req_a_q[29:14] == MMIO_BASE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_a_d   = req_a_q;
    req_rw_d  = req_rw_q;
    req_din_d = req_din_q;
    req_wen_d = req_wen_q;
    m_ready_d = 1'b0;
    m_dout_d  = '0;
    led_d     = led_q;
    cyc_d     = cyc_q + 32'd1;
    sw_s1_d   = sw;
    sw_s2_d   = sw_s1_q;

    unique case (state_q)
      S_IDLE: begin
        if (m_strobe) begin
          req_a_d   = m_a[31:2];
          req_rw_d  = m_rw;
          req_din_d = m_din;
          req_wen_d = m_wen;
          cnt_d     = CW'(LATENCY);
          state_d   = (LATENCY == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Completion pulse and read data are captured on the edge entering ACK.
    if ((state_d == S_ACK) && (state_q != S_ACK)) begin
      m_ready_d = 1'b1;
      if (!cur_rw_c) begin
        m_dout_d = rd_data_c;
      end
    end

    if (wr_c && wr_mmio_c && (req_a_q[13:0] == OFF_LED)) begin
      if (req_wen_q[0]) led_d[7:0]  = req_din_q[7:0];
      if (req_wen_q[1]) led_d[15:8] = req_din_q[15:8];
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_a_q   <= '0;
      req_rw_q  <= 1'b0;
      req_din_q <= '0;
      req_wen_q <= '0;
      m_dout_q  <= '0;
      m_ready_q <= 1'b0;
      led_q     <= '0;
      cyc_q     <= '0;
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_a_q   <= req_a_d;
      req_rw_q  <= req_rw_d;
      req_din_q <= req_din_d;
      req_wen_q <= req_wen_d;
      m_dout_q  <= m_dout_d;
      m_ready_q <= m_ready_d;
      led_q     <= led_d;
      cyc_q     <= cyc_d;
      sw_s1_q   <= sw_s1_d;
      sw_s2_q   <= sw_s2_d;
    end
  end

  // RAM commit at the edge ending ACK; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_c && !wr_mmio_c) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wen_q[i]) begin
          mem[req_a_q[MEM_AW-1:0]][8*i +: 8] <= req_din_q[8*i +: 8];
        end
      end
    end
  end

  assign m_dout  = m_dout_q;
  assign m_ready = m_ready_q;
  assign led     = led_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// Scoreboard bench for d_mem_responder: directed scenarios followed by random
// RAM/MMIO traffic checked against an array-based memory model.
module tb_d_mem_responder;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        clrn;
  logic        m_strobe;
  logic        m_rw;
  logic [31:0] m_a;
  logic [31:0] m_din;
  logic [3:0]  m_wen;
  logic [15:0] sw;
  logic [31:0] m_dout;
  logic        m_ready;
  logic [15:0] led;

  always #5 clk = ~clk;

  d_mem_responder #(.MEM_AW(12), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk), .clrn(clrn), .m_strobe(m_strobe), .m_rw(m_rw), .m_a(m_a),
    .m_din(m_din), .m_wen(m_wen), .sw(sw), .m_dout(m_dout),
    .m_ready(m_ready), .led(led)
  );

  typedef struct {
    bit          is_cnt;
    logic [31:0] data;
    int          ack_cyc;
    bit          led_wr;
    logic [15:0] led_new;
  } exp_t;

  exp_t        q[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          cyc        = 0;
  logic [31:0] cnt_model;
  logic [31:0] ram_m [int];
  logic [15:0] led_m   = 16'h0;
  logic [15:0] led_exp = 16'h0;
  bit          b2b     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference free-running counter: edges seen since reset release.
  always @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_model <= 32'h0;
    else       cnt_model <= cnt_model + 32'd1;
  end

  // Issue one transaction. mode 0: drop strobe after ready; 1: keep strobe
  // high into the next request; 2: abandon strobe in the first wait cycle.
  task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] w_in, input int mode);
    exp_t        e;
    int          cap;
    int          idx;
    bit          got;
    logic [3:0]  w;
    logic [31:0] word;
    w   = w_in;
    idx = int'(a[13:2]);
    if (!b2b) begin
      @(negedge clk);
      cap = cyc;
    end else begin
      cap = cyc + 1;
    end
    e.is_cnt  = 1'b0;
    e.data    = 32'h0;
    e.ack_cyc = cap + LAT + 1;
    e.led_wr  = 1'b0;
    e.led_new = led_m;
    if (a[31:16] == 16'h1faf) begin
      case (a[15:0] & 16'hfffc)
        16'h0000: begin
          if (rw) begin
            if (w[0]) led_m[7:0]  = d[7:0];
            if (w[1]) led_m[15:8] = d[15:8];
            e.led_wr  = 1'b1;
            e.led_new = led_m;
          end else begin
            e.data = {16'h0, led_m};
          end
        end
        16'h0004: if (!rw) e.data = {16'h0, sw};
        16'h0008: if (!rw) e.is_cnt = 1'b1;
        default: ;
      endcase
    end else if (rw) begin
      if (!ram_m.exists(idx)) begin
        w    = 4'hF;
        word = 32'h0;
      end else begin
        word = ram_m[idx];
      end
      for (int b = 0; b < 4; b++) if (w[b]) word[8*b +: 8] = d[8*b +: 8];
      ram_m[idx] = word;
    end else begin
      e.data = ram_m[idx];
    end
    q.push_back(e);
    m_strobe = 1'b1;
    m_rw     = rw;
    m_a      = a;
    m_din    = d;
    m_wen    = w;
    if (mode == 2) begin
      @(negedge clk);
      m_strobe = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = m_ready;
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL ready_timeout: no m_ready for address %h", a);
    end
    if (mode == 1) begin
      b2b = 1'b1;
    end else begin
      b2b      = 1'b0;
      m_strobe = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2;
    clrn     = 1'b0;
    m_strobe = 1'b0;
    led_m    = 16'h0;
    b2b      = 1'b0;
    repeat (n) @(negedge clk);
    #2;
    clrn = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] want;
    if (!clrn) led_exp = 16'h0;
    check("led", 32'(led), 32'(led_exp));
    if (m_ready) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_ready: m_ready=1 at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = q.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
        want = e.is_cnt ? (cnt_model - 32'd1) : e.data;
        check("m_dout", m_dout, want);
        if (e.led_wr) led_exp = e.led_new;
      end
    end else begin
      check("dout_idle", m_dout, 32'h0);
    end
  end

  initial begin
    logic        rw;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    logic [31:0] r;
    int          mode;
    clrn     = 1'b0;
    m_strobe = 1'b0;
    m_rw     = 1'b0;
    m_a      = 32'h0;
    m_din    = 32'h0;
    m_wen    = 4'h0;
    sw       = 16'h0;
    repeat (3) @(negedge clk);
    #2;
    clrn = 1'b1;

    // Preload, reset (RAM must survive), read back.
    req(1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 0);
    do_reset(2);
    req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0);

    // Byte-merge write.
    req(1'b1, 32'h0000_0020, 32'h11223344, 4'hF, 0);
    req(1'b1, 32'h0000_0020, 32'hAABBCCDD, 4'b0100, 0);
    req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);

    // MMIO: LED, switches, unmapped, counter.
    req(1'b1, 32'h1faf_0000, 32'h0000_A5A5, 4'hF, 0);
    sw = 16'h0F0F;
    repeat (4) @(negedge clk);
    req(1'b0, 32'h1faf_0004, 32'h0, 4'h0, 0);
    req(1'b0, 32'h1faf_0010, 32'h0, 4'h0, 0);
    req(1'b0, 32'h1faf_0008, 32'h0, 4'h0, 0);
    req(1'b0, 32'h1faf_0000, 32'h0, 4'h0, 0);

    // Strobe held high across two reads.
    req(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1);
    req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0);

    // Abandoned write still commits.
    req(1'b1, 32'h0000_0040, 32'h12345678, 4'hF, 2);
    req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0);

    // Reset during WAIT of a write discards it.
    req(1'b1, 32'h0000_0030, 32'h0000_0005, 4'hF, 0);
    @(negedge clk);
    m_strobe = 1'b1;
    m_rw     = 1'b1;
    m_a      = 32'h0000_0030;
    m_din    = 32'h0000_0099;
    m_wen    = 4'hF;
    @(negedge clk);
    #2;
    clrn     = 1'b0;
    m_strobe = 1'b0;
    led_m    = 16'h0;
    repeat (3) @(negedge clk);
    #2;
    clrn = 1'b1;
    req(1'b0, 32'h0000_0030, 32'h0, 4'h0, 0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      if (!b2b && ($urandom_range(0, 19) == 0)) begin
        sw = 16'($urandom);
        repeat (3) @(negedge clk);
      end
      rw = 1'($urandom_range(0, 1));
      d  = $urandom;
      w  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) < 7) begin
        a        = $urandom;
        a[13:2]  = 12'(16 + $urandom_range(0, 7));
        if (a[31:16] == 16'h1faf) a[31] = ~a[31];
        if (!rw && !ram_m.exists(int'(a[13:2]))) rw = 1'b1;
      end else begin
        r = 32'($urandom_range(0, 4));
        a = {16'h1faf, 16'h0};
        case (r)
          32'd0:   a[15:0] = 16'h0000;
          32'd1:   a[15:0] = 16'h0004;
          32'd2:   a[15:0] = 16'h0008;
          32'd3:   a[15:0] = 16'h0010;
          default: a[15:0] = 16'($urandom);
        endcase
        a[1:0] = 2'($urandom_range(0, 3));
      end
      if (n == 299) mode = 0;
      else if (!b2b && rw && ($urandom_range(0, 5) == 0)) mode = 2;
      else mode = $urandom_range(0, 1);
      req(rw, a, d, w, mode);
      if (!b2b) repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
